// File: rtl/butterfly_twiddle_pipe.sv
// Pipelined radix-2 DIT butterfly: X = A + W'*B, Y = A - W'*B in signed Q1.(WIDTH-1),
// with optional conj(W), per-sample halving, output saturation and a sticky clip flag.
module butterfly_twiddle_pipe #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PIPE_EXTRA = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_r,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_r,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] w_r,
    input  logic [WIDTH-1:0] w_i,
    input  logic             inverse,
    input  logic             scale,
    input  logic             clear_sat,
    output logic [WIDTH-1:0] x_r,
    output logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_r,
    output logic [WIDTH-1:0] y_i,
    output logic             out_valid,
    output logic             sat_flag
);

    localparam int unsigned PW    = 2 * WIDTH + 2;
    localparam int unsigned RW    = WIDTH + 2;
    localparam int unsigned SW    = WIDTH + 3;
    localparam int unsigned OW    = 4 * WIDTH + 1;
    localparam int unsigned Depth = PIPE_EXTRA + 1;

    localparam logic signed [PW-1:0] RoundK = PW'(1) << (WIDTH - 2);
    localparam logic signed [SW-1:0] One    = SW'(1);
    localparam logic signed [SW-1:0] MaxS   = {4'b0000, {(WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] MinS   = {4'b1111, {(WIDTH - 1){1'b0}}};

    if (PIPE_EXTRA > 2) begin : gen_bad_pipe_extra
        $error("butterfly_twiddle_pipe: PIPE_EXTRA must be in 0..2");
    end

    function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] v,
                                                   input logic en);
        logic signed [SW-1:0] t;
        t = v + One;
        return en ? (t >>> 1) : v;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [WIDTH:0] saturate(input logic signed [SW-1:0] v);
        if (v > MaxS) begin
            return {1'b1, 1'b0, {(WIDTH - 1){1'b1}}};
        end else if (v < MinS) begin
            return {1'b1, 1'b1, {(WIDTH - 1){1'b0}}};
        end
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    // Stage 1: capture operands; conj(W) negates at WIDTH+1 bits so -(-2^(W-1)) is exact.
    logic signed [WIDTH:0]   w_i_ext, w_i_mod;
    logic signed [WIDTH-1:0] a_r1_q, a_i1_q, b_r1_q, b_i1_q, w_r1_q;
    logic signed [WIDTH:0]   w_i1_q;
    logic                    v1_q, scale1_q;

    assign w_i_ext = {w_i[WIDTH-1], w_i};
    assign w_i_mod = inverse ? -w_i_ext : w_i_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r1_q   <= '0;
            a_i1_q   <= '0;
            b_r1_q   <= '0;
            b_i1_q   <= '0;
            w_r1_q   <= '0;
            w_i1_q   <= '0;
            v1_q     <= 1'b0;
            scale1_q <= 1'b0;
        end else if (enable) begin
            a_r1_q   <= a_r;
            a_i1_q   <= a_i;
            b_r1_q   <= b_r;
            b_i1_q   <= b_i;
            w_r1_q   <= w_r;
            w_i1_q   <= w_i_mod;
            v1_q     <= in_valid;
            scale1_q <= scale;
        end
    end

    // Stage 2: full-precision complex product, round-half-up then floor shift.
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir, p_r_full, p_i_full;
    logic signed [RW-1:0] p_r_d, p_i_d;
    logic signed [WIDTH-1:0] a_r2_q, a_i2_q;
    logic signed [RW-1:0]    p_r2_q, p_i2_q;
    logic                    v2_q, scale2_q;

    assign p_rr     = PW'(b_r1_q) * PW'(w_r1_q);
    assign p_ii     = PW'(b_i1_q) * PW'(w_i1_q);
    assign p_ri     = PW'(b_r1_q) * PW'(w_i1_q);
    assign p_ir     = PW'(b_i1_q) * PW'(w_r1_q);
    assign p_r_full = p_rr - p_ii + RoundK;
    assign p_i_full = p_ri + p_ir + RoundK;
    assign p_r_d    = RW'(p_r_full >>> (WIDTH - 1));
    assign p_i_d    = RW'(p_i_full >>> (WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r2_q   <= '0;
            a_i2_q   <= '0;
            p_r2_q   <= '0;
            p_i2_q   <= '0;
            v2_q     <= 1'b0;
            scale2_q <= 1'b0;
        end else if (enable) begin
            a_r2_q   <= a_r1_q;
            a_i2_q   <= a_i1_q;
            p_r2_q   <= p_r_d;
            p_i2_q   <= p_i_d;
            v2_q     <= v1_q;
            scale2_q <= scale1_q;
        end
    end

    // Stage 3: sum/difference, optional halving, saturation.
    logic signed [SW-1:0] s_r, s_i, d_r, d_i;
    logic [WIDTH:0]       sat_xr, sat_xi, sat_yr, sat_yi;
    logic                 s3_clip;
    logic [OW-1:0]        s3_word;

    assign s_r = halve(SW'(a_r2_q) + SW'(p_r2_q), scale2_q);
    assign s_i = halve(SW'(a_i2_q) + SW'(p_i2_q), scale2_q);
    assign d_r = halve(SW'(a_r2_q) - SW'(p_r2_q), scale2_q);
    assign d_i = halve(SW'(a_i2_q) - SW'(p_i2_q), scale2_q);

    assign sat_xr  = saturate(s_r);
    assign sat_xi  = saturate(s_i);
    assign sat_yr  = saturate(d_r);
    assign sat_yi  = saturate(d_i);
    assign s3_clip = sat_xr[WIDTH] | sat_xi[WIDTH] | sat_yr[WIDTH] | sat_yi[WIDTH];
    assign s3_word = {v2_q, sat_xr[WIDTH-1:0], sat_xi[WIDTH-1:0],
                      sat_yr[WIDTH-1:0], sat_yi[WIDTH-1:0]};

    // Output register followed by PIPE_EXTRA delay stages: {valid, x_r, x_i, y_r, y_i}.
    logic [OW-1:0] out_q [Depth];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < Depth; k++) begin
                out_q[k] <= '0;
            end
        end else if (enable) begin
            out_q[0] <= s3_word;
            for (int unsigned k = 1; k < Depth; k++) begin
                out_q[k] <= out_q[k-1];
            end
        end
    end

    assign {out_valid, x_r, x_i, y_r, y_i} = out_q[PIPE_EXTRA];

    // Flag rises on the same edge that presents the clipped valid sample at the outputs.
    logic sat_set;

    if (PIPE_EXTRA == 0) begin : gen_sat_direct
        assign sat_set = v2_q & s3_clip;
    end else begin : gen_sat_delayed
        logic clip_q [PIPE_EXTRA];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned k = 0; k < PIPE_EXTRA; k++) begin
                    clip_q[k] <= 1'b0;
                end
            end else if (enable) begin
                clip_q[0] <= s3_clip;
                for (int unsigned k = 1; k < PIPE_EXTRA; k++) begin
                    clip_q[k] <= clip_q[k-1];
                end
            end
        end

        assign sat_set = out_q[PIPE_EXTRA-1][OW-1] & clip_q[PIPE_EXTRA-1];
    end

    logic sat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (enable && sat_set) begin
            sat_q <= 1'b1;
        end else if (clear_sat) begin
            sat_q <= 1'b0;
        end
    end

    assign sat_flag = sat_q;

endmodule

// File: tb/tb_butterfly_twiddle_pipe.sv
// Scoreboard bench for butterfly_twiddle_pipe; two instances (PIPE_EXTRA 0 and 2) share stimulus.
module tb_butterfly_twiddle_pipe;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, inverse, scale, clear_sat;
    logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i;
    logic [15:0] x_r0, x_i0, y_r0, y_i0, x_r2, x_i2, y_r2, y_i2;
    logic        out_valid0, sat0, out_valid2, sat2;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    typedef struct packed {
        logic [15:0] xr;
        logic [15:0] xi;
        logic [15:0] yr;
        logic [15:0] yi;
        logic        clip;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    butterfly_twiddle_pipe #(.WIDTH(16), .PIPE_EXTRA(0)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .w_r(w_r), .w_i(w_i),
        .inverse(inverse), .scale(scale), .clear_sat(clear_sat),
        .x_r(x_r0), .x_i(x_i0), .y_r(y_r0), .y_i(y_i0),
        .out_valid(out_valid0), .sat_flag(sat0)
    );

    butterfly_twiddle_pipe #(.WIDTH(16), .PIPE_EXTRA(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .w_r(w_r), .w_i(w_i),
        .inverse(inverse), .scale(scale), .clear_sat(clear_sat),
        .x_r(x_r2), .x_i(x_i2), .y_r(y_r2), .y_i(y_i2),
        .out_valid(out_valid2), .sat_flag(sat2)
    );

    function automatic logic [15:0] clip16(input longint v, output bit c);
        if (v > 32767) begin
            c = 1'b1;
            return 16'h7FFF;
        end
        if (v < -32768) begin
            c = 1'b1;
            return 16'h8000;
        end
        c = 1'b0;
        return v[15:0];
    endfunction

    function automatic exp_t model(input logic [15:0] ar, ai, br, bi, wr, wi,
                                   input bit inv, scl);
        exp_t   e;
        longint sar, sai, sbr, sbi, swr, swi, wip, pr, pi, sr, si, dr, di;
        bit     c0, c1, c2, c3;
        sar = longint'($signed(ar));
        sai = longint'($signed(ai));
        sbr = longint'($signed(br));
        sbi = longint'($signed(bi));
        swr = longint'($signed(wr));
        swi = longint'($signed(wi));
        wip = inv ? -swi : swi;
        pr  = sbr * swr - sbi * wip;
        pi  = sbr * wip + sbi * swr;
        pr  = (pr + 16384) >>> 15;
        pi  = (pi + 16384) >>> 15;
        sr  = sar + pr;
        si  = sai + pi;
        dr  = sar - pr;
        di  = sai - pi;
        if (scl) begin
            sr = (sr + 1) >>> 1;
            si = (si + 1) >>> 1;
            dr = (dr + 1) >>> 1;
            di = (di + 1) >>> 1;
        end
        e.xr   = clip16(sr, c0);
        e.xi   = clip16(si, c1);
        e.yr   = clip16(dr, c2);
        e.yi   = clip16(di, c3);
        e.clip = c0 | c1 | c2 | c3;
        e.due  = 0;
        return e;
    endfunction

    // Scoreboard monitor: pops on every enabled edge, checks values and enabled-cycle latency.
    exp_t e0, e2;
    bit   upd;
    always @(posedge clk) begin
        upd = enable && !reset;
        if (upd) ecnt++;
        #2;
        if (upd) begin
            if (out_valid0) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL dut0_unexpected_valid: out_valid=1 at cycle %0d, none due", ecnt);
                end else begin
                    e0 = q0.pop_front();
                    if ({x_r0, x_i0, y_r0, y_i0} !== {e0.xr, e0.xi, e0.yr, e0.yi} || ecnt != e0.due) begin
                        bad++;
                        $display("FAIL dut0_out: got x=(%h,%h) y=(%h,%h) @%0d want x=(%h,%h) y=(%h,%h) @%0d",
                                 x_r0, x_i0, y_r0, y_i0, ecnt, e0.xr, e0.xi, e0.yr, e0.yi, e0.due);
                    end
                end
            end else if (q0.size() != 0 && q0[0].due <= ecnt) begin
                total++;
                bad++;
                $display("FAIL dut0_missing: out_valid=0 at cycle %0d, sample due at %0d", ecnt, q0[0].due);
                void'(q0.pop_front());
            end
            if (out_valid2) begin
                total++;
                if (q2.size() == 0) begin
                    bad++;
                    $display("FAIL dut2_unexpected_valid: out_valid=1 at cycle %0d, none due", ecnt);
                end else begin
                    e2 = q2.pop_front();
                    if ({x_r2, x_i2, y_r2, y_i2} !== {e2.xr, e2.xi, e2.yr, e2.yi} || ecnt != e2.due) begin
                        bad++;
                        $display("FAIL dut2_out: got x=(%h,%h) y=(%h,%h) @%0d want x=(%h,%h) y=(%h,%h) @%0d",
                                 x_r2, x_i2, y_r2, y_i2, ecnt, e2.xr, e2.xi, e2.yr, e2.yi, e2.due);
                    end
                end
            end else if (q2.size() != 0 && q2[0].due <= ecnt) begin
                total++;
                bad++;
                $display("FAIL dut2_missing: out_valid=0 at cycle %0d, sample due at %0d", ecnt, q2[0].due);
                void'(q2.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        enable   = 1'b1;
        repeat (n) step();
    endtask

    task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi, input bit inv, scl,
                        output bit clip);
        exp_t e;
        a_r = ar; a_i = ai; b_r = br; b_i = bi; w_r = wr; w_i = wi;
        inverse  = inv;
        scale    = scl;
        in_valid = 1'b1;
        enable   = 1'b1;
        e     = model(ar, ai, br, bi, wr, wi, inv, scl);
        clip  = e.clip;
        e.due = ecnt + 3;
        q0.push_back(e);
        e.due = ecnt + 5;
        q2.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        in_valid = 1'b0;
        enable   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (q0.size() == 0 && q2.size() == 0) break;
            step();
        end
        ok = (q0.size() == 0 && q2.size() == 0);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid0, sat0, x_r0, x_i0, y_r0, y_i0} !== '0) begin
            bad++;
            $display("FAIL reset_dut0: got v=%b s=%b x=(%h,%h) y=(%h,%h) want all 0",
                     out_valid0, sat0, x_r0, x_i0, y_r0, y_i0);
        end
        total++;
        if ({out_valid2, sat2, x_r2, x_i2, y_r2, y_i2} !== '0) begin
            bad++;
            $display("FAIL reset_dut2: got v=%b s=%b x=(%h,%h) y=(%h,%h) want all 0",
                     out_valid2, sat2, x_r2, x_i2, y_r2, y_i2);
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if ({out_valid0, out_valid2} !== 2'b00) begin
                bad++;
                $display("FAIL reset_idle_valid: got %b%b want 00", out_valid0, out_valid2);
            end
        end
    endtask

    task automatic test_basic();
        bit c, ok;
        send(16'h1000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, c);
        for (int k = 1; k <= 6; k++) begin
            total++;
            if (out_valid0 !== (k == 3) || out_valid2 !== (k == 5)) begin
                bad++;
                $display("FAIL basic_latency: after %0d edges got v0=%b v2=%b want %b %b",
                         k, out_valid0, out_valid2, k == 3, k == 5);
            end
            if (k == 3) begin
                total++;
                if ({x_r0, x_i0, y_r0, y_i0} !== 64'h3000_0000_F000_0000) begin
                    bad++;
                    $display("FAIL basic_value0: got %h %h %h %h want 3000 0000 f000 0000",
                             x_r0, x_i0, y_r0, y_i0);
                end
            end
            if (k == 5) begin
                total++;
                if ({x_r2, x_i2, y_r2, y_i2} !== 64'h3000_0000_F000_0000) begin
                    bad++;
                    $display("FAIL basic_value2: got %h %h %h %h want 3000 0000 f000 0000",
                             x_r2, x_i2, y_r2, y_i2);
                end
            end
            step();
        end
        drain(ok);
        total++;
        if (!ok || sat0 !== 1'b0 || sat2 !== 1'b0) begin
            bad++;
            $display("FAIL basic_sat: got drained=%b sat=%b%b want 1 00", ok, sat0, sat2);
        end
    endtask

    task automatic test_inverse();
        bit c, ok;
        send(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b0, c);
        send(16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h8000, 1'b1, 1'b0, c);
        step();
        total++;
        if ({x_r0, x_i0, y_r0, y_i0} !== 64'h0000_E000_0000_2000) begin
            bad++;
            $display("FAIL inverse_off: got %h %h %h %h want 0000 e000 0000 2000",
                     x_r0, x_i0, y_r0, y_i0);
        end
        step();
        total++;
        if ({x_r0, x_i0, y_r0, y_i0} !== 64'h0000_2000_0000_E000) begin
            bad++;
            $display("FAIL inverse_on: got %h %h %h %h want 0000 2000 0000 e000",
                     x_r0, x_i0, y_r0, y_i0);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL inverse_drain: got pending %0d/%0d want 0/0", q0.size(), q2.size());
        end
    endtask

    task automatic test_saturation();
        bit c, ok;
        send(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, c);
        repeat (2) step();
        total++;
        if ({out_valid0, x_r0, y_r0, sat0} !== {1'b1, 16'h7FFF, 16'h0001, 1'b1}) begin
            bad++;
            $display("FAIL sat_value: got v=%b xr=%h yr=%h sat=%b want 1 7fff 0001 1",
                     out_valid0, x_r0, y_r0, sat0);
        end
        drain(ok);
        idle(3);
        total++;
        if (!ok || sat0 !== 1'b1 || sat2 !== 1'b1) begin
            bad++;
            $display("FAIL sat_held: got drained=%b sat=%b%b want 1 11", ok, sat0, sat2);
        end
        enable    = 1'b0;
        clear_sat = 1'b1;
        step();
        clear_sat = 1'b0;
        enable    = 1'b1;
        total++;
        if (sat0 !== 1'b0 || sat2 !== 1'b0) begin
            bad++;
            $display("FAIL sat_clear: got sat=%b%b want 00", sat0, sat2);
        end
        send(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1, c);
        repeat (2) step();
        total++;
        if ({out_valid0, x_r0, y_r0} !== {1'b1, 16'h7000, 16'h0001}) begin
            bad++;
            $display("FAIL scale_value: got v=%b xr=%h yr=%h want 1 7000 0001",
                     out_valid0, x_r0, y_r0);
        end
        drain(ok);
        total++;
        if (!ok || sat0 !== 1'b0 || sat2 !== 1'b0) begin
            bad++;
            $display("FAIL scale_sat: got drained=%b sat=%b%b want 1 00", ok, sat0, sat2);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v[6];
        bit          c, ok, exp_sat;
        exp_sat = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n == 4) begin
                // Stalled cycles with a bogus valid sample that must not be taken.
                enable   = 1'b0;
                in_valid = 1'b1;
                a_r      = 16'h5555;
                b_r      = 16'h2AAA;
                repeat (2) step();
            end
            for (int j = 0; j < 6; j++) v[j] = 16'($urandom);
            send(v[0], v[1], v[2], v[3], v[4], v[5], 1'($urandom), 1'($urandom), c);
            exp_sat = exp_sat | c;
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stream_drain: got pending %0d/%0d want 0/0", q0.size(), q2.size());
        end
        total++;
        if (sat0 !== exp_sat || sat2 !== exp_sat) begin
            bad++;
            $display("FAIL stream_sat: got sat=%b%b want %b%b", sat0, sat2, exp_sat, exp_sat);
        end
        clear_sat = 1'b1;
        step();
        clear_sat = 1'b0;
    endtask

    task automatic test_async_reset();
        bit c, ok;
        send(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, c);
        drain(ok);
        send(16'h1000, 16'h0100, 16'h2000, 16'h0300, 16'h4000, 16'h1000, 1'b0, 1'b0, c);
        send(16'h0800, 16'h0200, 16'h1000, 16'h0400, 16'h2000, 16'h3000, 1'b1, 1'b0, c);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({out_valid0, sat0, x_r0, x_i0, y_r0, y_i0} !== '0 ||
            {out_valid2, sat2, x_r2, x_i2, y_r2, y_i2} !== '0) begin
            bad++;
            $display("FAIL async_reset: got v=%b%b s=%b%b x0=(%h,%h) x2=(%h,%h) want all 0",
                     out_valid0, out_valid2, sat0, sat2, x_r0, x_i0, x_r2, x_i2);
        end
        q0.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if ({out_valid0, out_valid2} !== 2'b00) begin
                bad++;
                $display("FAIL post_reset_stale: got v=%b%b want 00", out_valid0, out_valid2);
            end
        end
        send(16'h1000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, c);
        repeat (2) step();
        total++;
        if ({out_valid0, x_r0, y_r0} !== {1'b1, 16'h3000, 16'hF000}) begin
            bad++;
            $display("FAIL post_reset_sample: got v=%b xr=%h yr=%h want 1 3000 f000",
                     out_valid0, x_r0, y_r0);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL post_reset_drain: got pending %0d/%0d want 0/0", q0.size(), q2.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; in_valid = 1'b0; inverse = 1'b0; scale = 1'b0;
        clear_sat = 1'b0;
        a_r = '0; a_i = '0; b_r = '0; b_i = '0; w_r = '0; w_i = '0;
        test_reset();
        test_basic();
        test_inverse();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/butterfly_twiddle_pipe.md
Name: butterfly_twiddle_pipe

Overview:
Parametrised, pipelined radix-2 DIT butterfly with an integrated twiddle multiplier, in signed fixed point. Computes X = A + W·B and Y = A − W·B per valid sample. Supports an inverse mode using conj(W), optional per-sample 1/2 scaling, output saturation with a sticky flag, a global stall enable, and configurable extra output pipeline depth. It is the per-stage compute element for the FFT/IFFT datapath of the OFDM chain.

Parameters:
WIDTH, 16, bit width of each real/imag component; signed Q1.(WIDTH-1).
PIPE_EXTRA, 0, extra output register stages (0..2); total latency = 3 + PIPE_EXTRA.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = pipeline advances; 0 = every stage, including out_valid, holds
in_valid  in  1  input sample valid; sampled only when enable=1
a_r, a_i  in  WIDTH  operand A, real/imag
b_r, b_i  in  WIDTH  operand B, real/imag
w_r, w_i  in  WIDTH  twiddle W, real/imag
inverse  in  1  1 = use conj(W); travels with the sample
scale  in  1  1 = halve both outputs; travels with the sample
clear_sat  in  1  synchronous clear of sat_flag
x_r, x_i  out  WIDTH  X = A + W'·B
y_r, y_i  out  WIDTH  Y = A − W'·B
out_valid  out  1  X/Y valid
sat_flag  out  1  sticky; set if any output component saturated

Behaviour:
- Reset (async assert, sync deassert on clk): all pipeline registers, x/y outputs, out_valid and sat_flag go to 0.
- Stage 1: register a, b, w, in_valid, inverse, scale. If inverse=1, W' = (w_r, −w_i), negated at WIDTH+1 bits so that −(−2^(W-1)) is exact.
- Stage 2: complex product P = W'·B at full precision (2·WIDTH+2 bits). Pr = br·wr − bi·wi', Pi = br·wi' + bi·wr. Round: add 2^(WIDTH-2), arithmetic shift right by WIDTH-1 (floor), keep WIDTH+2 bits with no saturation at this stage. Register P, A delayed, and control.
- Stage 3: S = A + P, D = A − P at WIDTH+3 bits. If scale=1: S = (S+1)>>>1, D = (D+1)>>>1. Saturate each component to [−2^(WIDTH-1), 2^(WIDTH-1)−1] and register it to the x/y outputs.
- sat_flag is set when any of the four components clips while its out_valid is asserted. clear_sat=1 clears it. If clip and clear_sat occur in the same cycle, set wins.
- PIPE_EXTRA stages delay x, y and out_valid identically. Values outside 0..2 are a configuration error, flagged by an elaboration assertion.
- out_valid = in_valid delayed by 3+PIPE_EXTRA enabled cycles. Data registers load on every enabled cycle regardless of valid. Data accompanying out_valid=0 is don't-care.
- enable=0: no register changes, except that clear_sat still acts. Throughput is 1 sample per enabled cycle; there is no backpressure beyond enable.
- Reset mid-stream: all in-flight samples are discarded, and out_valid=0 until new samples traverse the full latency.

Test Plan:
1. WIDTH=16, PIPE_EXTRA=0; A=(0x1000,0), B=(0x2000,0), W=(0x7FFF,0), in_valid=1 -> exactly 3 enabled cycles later out_valid=1, X=(0x3000,0), Y=(0xF000,0), sat_flag=0.
2. A=(0,0), B=(0x2000,0), W=(0,0x8000), inverse=0 -> X=(0,0xE000), Y=(0,0x2000). Same stimulus with inverse=1 -> X=(0,0x2000), Y=(0,0xE000).
3. A=(0x7000,0), B=(0x7000,0), W=(0x7FFF,0), scale=0 -> X.r=0x7FFF (saturated), Y.r=0x0001, sat_flag=1 and held. Then clear_sat=1 for one cycle -> sat_flag=0. Same stimulus with scale=1 -> X.r=0x7000, Y.r=0x0001, sat_flag stays 0.
4. Stream of 8 back-to-back valid samples, with enable=0 for 2 cycles mid-stream -> outputs appear in order with no loss or duplication, each at input cycle + 3 + number of stalled cycles.
5. PIPE_EXTRA=2, repeat scenario 1 -> identical values, out_valid exactly 5 cycles after input.
6. Assert reset asynchronously (between clock edges) with 2 samples in flight -> outputs and out_valid go to 0 immediately, no stale sample emerges afterwards, and the first post-reset sample emerges after full latency.
